// File: rtl/gen_rot_addr_frame_pkg.sv
// Shared definitions for the rotation frame address generator:
// FSM state encoding, transform mode constants and Q-format helpers.
package gen_rot_addr_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_LINE = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic MODE_IDENT = 1'b0;
  localparam logic MODE_ROT   = 1'b1;

  // Value of 1.0 in a fixed-point format with frac_w fractional bits.
  function automatic int unsigned q_one(input int unsigned frac_w);
    return 32'd1 << frac_w;
  endfunction

endpackage

// File: rtl/gen_rot_addr_frame_rot_row_base.sv
// Row base accumulators for one destination row: source position of dest_x=0
// after rotation about the frame centre. Holds the only multipliers of the block.
module rot_row_base
  import gen_rot_addr_frame_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int TRIG_W   = 16,
  parameter int FRAC_W   = 14,
  parameter int ACC_W    = ADDR_W + FRAC_W + 3
) (
  input  logic        [ADDR_W-1:0] dest_y_i,
  input  logic signed [TRIG_W-1:0] cos_i,
  input  logic signed [TRIG_W-1:0] sin_i,
  output logic signed [ACC_W-1:0]  bx_o,
  output logic signed [ACC_W-1:0]  by_o
);

  // The centre sits on a half pixel, so everything is built at twice the
  // value and halved (floor) at the end to keep it exact.
  localparam logic signed [ACC_W-1:0] HM1   = ACC_W'(H_ACTIVE - 1);
  localparam logic signed [ACC_W-1:0] VM1   = ACC_W'(V_ACTIVE - 1);
  localparam logic signed [ACC_W-1:0] HM1_Q = ACC_W'((H_ACTIVE - 1) * q_one(FRAC_W));
  localparam logic signed [ACC_W-1:0] VM1_Q = ACC_W'((V_ACTIVE - 1) * q_one(FRAC_W));

  logic signed [ACC_W-1:0] cos_w;
  logic signed [ACC_W-1:0] sin_w;
  logic signed [ACC_W-1:0] off_y_w;
  logic signed [ACC_W-1:0] sum2_x_w;
  logic signed [ACC_W-1:0] sum2_y_w;

  // Doubled row base: 2*bx = cos*(-2Cx) + sin*(2y-2Cy) + 2Cx, likewise for by.
  always_comb begin
    cos_w    = {{(ACC_W-TRIG_W){cos_i[TRIG_W-1]}}, cos_i};
    sin_w    = {{(ACC_W-TRIG_W){sin_i[TRIG_W-1]}}, sin_i};
    off_y_w  = $signed({{(ACC_W-ADDR_W-1){1'b0}}, dest_y_i, 1'b0}) - VM1;
    sum2_x_w = (sin_w * off_y_w) - (cos_w * HM1) + HM1_Q;
    sum2_y_w = (sin_w * HM1) + (cos_w * off_y_w) + VM1_Q;
    bx_o     = sum2_x_w >>> 1;
    by_o     = sum2_y_w >>> 1;
  end

endmodule

// File: rtl/gen_rot_addr_frame.sv
// Frame address generator: walks destination pixels in raster order and emits
// the rotated (or identity) source coordinate into the address FIFO.
module gen_rot_addr_frame
  import gen_rot_addr_frame_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int TRIG_W   = 16,
  parameter int FRAC_W   = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic                     mode,
  input  logic signed [TRIG_W-1:0] cos_in,
  input  logic signed [TRIG_W-1:0] sin_in,
  input  logic                     addr_fifo_full,
  output logic                     wr_en,
  output logic        [ADDR_W-1:0] addr_x,
  output logic        [ADDR_W-1:0] addr_y,
  output logic                     addr_oob,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int ACC_W = ADDR_W + FRAC_W + 3;
  localparam logic signed [TRIG_W-1:0] ONE_Q  = TRIG_W'(q_one(FRAC_W));
  localparam logic signed [ACC_W-1:0]  HALF_Q = ACC_W'(q_one(FRAC_W) >> 1);
  localparam logic signed [ACC_W-1:0]  XMAX   = ACC_W'(H_ACTIVE - 1);
  localparam logic signed [ACC_W-1:0]  YMAX   = ACC_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0]        XLAST  = ADDR_W'(H_ACTIVE - 1);
  localparam logic [ADDR_W-1:0]        YLAST  = ADDR_W'(V_ACTIVE - 1);

  state_e                  state_q;
  logic                    mode_q;
  logic signed [TRIG_W-1:0] cos_q;
  logic signed [TRIG_W-1:0] sin_q;
  logic [ADDR_W-1:0]       dest_x_q;
  logic [ADDR_W-1:0]       dest_y_q;
  logic signed [ACC_W-1:0] ax_q;
  logic signed [ACC_W-1:0] ay_q;
  logic                    wr_en_q;
  logic [ADDR_W-1:0]       addr_x_q;
  logic [ADDR_W-1:0]       addr_y_q;
  logic                    addr_oob_q;
  logic                    busy_q;
  logic                    frame_done_q;

  logic signed [TRIG_W-1:0] cos_eff_d;
  logic signed [TRIG_W-1:0] sin_eff_d;
  logic signed [ACC_W-1:0]  cos_acc_d;
  logic signed [ACC_W-1:0]  sin_acc_d;
  logic signed [ACC_W-1:0]  bx_d;
  logic signed [ACC_W-1:0]  by_d;
  logic signed [ACC_W-1:0]  sx_d;
  logic signed [ACC_W-1:0]  sy_d;
  logic                     oob_d;

  // Identity runs through the same datapath as a rotation by 0 degrees,
  // which yields exact integer coordinates and keeps the timing identical.
  always_comb begin
    if (mode_q == MODE_ROT) begin
      cos_eff_d = cos_q;
      sin_eff_d = sin_q;
    end else begin
      cos_eff_d = ONE_Q;
      sin_eff_d = {TRIG_W{1'b0}};
    end
    cos_acc_d = {{(ACC_W-TRIG_W){cos_eff_d[TRIG_W-1]}}, cos_eff_d};
    sin_acc_d = {{(ACC_W-TRIG_W){sin_eff_d[TRIG_W-1]}}, sin_eff_d};
  end

  rot_row_base #(
    .ADDR_W   (ADDR_W),
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .TRIG_W   (TRIG_W),
    .FRAC_W   (FRAC_W),
    .ACC_W    (ACC_W)
  ) u_row_base (
    .dest_y_i (dest_y_q),
    .cos_i    (cos_eff_d),
    .sin_i    (sin_eff_d),
    .bx_o     (bx_d),
    .by_o     (by_d)
  );

  // Round-half-up to integer source pixel and range check.
  always_comb begin
    sx_d  = (ax_q + HALF_Q) >>> FRAC_W;
    sy_d  = (ay_q + HALF_Q) >>> FRAC_W;
    oob_d = sx_d[ACC_W-1] | (sx_d > XMAX) | sy_d[ACC_W-1] | (sy_d > YMAX);
  end

  // Frame sequencer with registered FIFO-side outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_IDENT;
      cos_q        <= {TRIG_W{1'b0}};
      sin_q        <= {TRIG_W{1'b0}};
      dest_x_q     <= {ADDR_W{1'b0}};
      dest_y_q     <= {ADDR_W{1'b0}};
      ax_q         <= {ACC_W{1'b0}};
      ay_q         <= {ACC_W{1'b0}};
      wr_en_q      <= 1'b0;
      addr_x_q     <= {ADDR_W{1'b0}};
      addr_y_q     <= {ADDR_W{1'b0}};
      addr_oob_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            mode_q  <= mode;
            cos_q   <= cos_in;
            sin_q   <= sin_in;
            busy_q  <= 1'b1;
            state_q <= ST_INIT;
          end
        end
        ST_INIT: begin
          dest_x_q <= {ADDR_W{1'b0}};
          dest_y_q <= {ADDR_W{1'b0}};
          state_q  <= ST_LINE;
        end
        ST_LINE: begin
          ax_q     <= bx_d;
          ay_q     <= by_d;
          dest_x_q <= {ADDR_W{1'b0}};
          state_q  <= ST_RUN;
        end
        ST_RUN: begin
          // A full FIFO freezes the walk; nothing advances without a write.
          if (!addr_fifo_full) begin
            wr_en_q    <= 1'b1;
            addr_oob_q <= oob_d;
            addr_x_q   <= oob_d ? {ADDR_W{1'b0}} : sx_d[ADDR_W-1:0];
            addr_y_q   <= oob_d ? {ADDR_W{1'b0}} : sy_d[ADDR_W-1:0];
            ax_q       <= ax_q + cos_acc_d;
            ay_q       <= ay_q - sin_acc_d;
            if (dest_x_q == XLAST) begin
              dest_x_q <= {ADDR_W{1'b0}};
              if (dest_y_q == YLAST) begin
                state_q <= ST_DONE;
              end else begin
                dest_y_q <= dest_y_q + ADDR_W'(1);
                state_q  <= ST_LINE;
              end
            end else begin
              dest_x_q <= dest_x_q + ADDR_W'(1);
            end
          end
        end
        ST_DONE: begin
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_en      = wr_en_q;
  assign addr_x     = addr_x_q;
  assign addr_y     = addr_y_q;
  assign addr_oob   = addr_oob_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gen_rot_addr_frame.sv
// Scoreboard bench for gen_rot_addr_frame on an 8x4 frame: expected source
// coordinates come from a rational-arithmetic rotation model.
module tb_gen_rot_addr_frame;

  localparam int H         = 8;
  localparam int V         = 4;
  localparam int AW        = 11;
  localparam int TW        = 16;
  localparam int FW        = 14;
  localparam int ONE       = 16384;
  localparam int NPIX      = H * V;
  localparam int FRAME_CYC = V * (H + 1) + 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 frame_start = 1'b0;
  logic                 mode = 1'b0;
  logic signed [TW-1:0] cos_in = '0;
  logic signed [TW-1:0] sin_in = '0;
  logic                 addr_fifo_full = 1'b0;
  logic                 wr_en;
  logic [AW-1:0]        addr_x;
  logic [AW-1:0]        addr_y;
  logic                 addr_oob;
  logic                 busy;
  logic                 frame_done;

  gen_rot_addr_frame #(
    .ADDR_W   (AW),
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .TRIG_W   (TW),
    .FRAC_W   (FW)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .frame_start    (frame_start),
    .mode           (mode),
    .cos_in         (cos_in),
    .sin_in         (sin_in),
    .addr_fifo_full (addr_fifo_full),
    .wr_en          (wr_en),
    .addr_x         (addr_x),
    .addr_y         (addr_y),
    .addr_oob       (addr_oob),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    bit oob;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   wr_cnt = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  bit   done_seen = 1'b0;
  bit   lat_chk = 1'b0;
  bit   full_s = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    full_s <= addr_fifo_full;
  end

  // Source pixel = R * (dest - C) + C with C=((H-1)/2,(V-1)/2), values in
  // Q.FW held at twice their size so the half-pixel centre stays exact; the
  // accumulator keeps floor of the halved value, then rounds half-up.
  function automatic exp_t model(input int dx, input int dy, input bit md, input int c, input int s);
    exp_t  r;
    longint nx, ny, sx, sy;
    if (!md) begin
      r.x = dx; r.y = dy; r.oob = 1'b0;
    end else begin
      nx = longint'(c) * longint'(2 * dx - (H - 1)) + longint'(s) * longint'(2 * dy - (V - 1))
           + longint'(H - 1) * longint'(ONE);
      ny = longint'(c) * longint'(2 * dy - (V - 1)) - longint'(s) * longint'(2 * dx - (H - 1))
           + longint'(V - 1) * longint'(ONE);
      sx = ((nx >>> 1) + longint'(ONE / 2)) >>> FW;
      sy = ((ny >>> 1) + longint'(ONE / 2)) >>> FW;
      r.oob = (sx < 0) || (sx > H - 1) || (sy < 0) || (sy > V - 1);
      r.x = r.oob ? 0 : int'(sx);
      r.y = r.oob ? 0 : int'(sy);
    end
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on every write and checks frame completion.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (full_s) chk("wr_while_full", int'(wr_en), 0);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_write got=(%0d,%0d) want=none", addr_x, addr_y);
        end else begin
          e = exp_q.pop_front();
          chk("addr_x", int'(addr_x), e.x);
          chk("addr_y", int'(addr_y), e.y);
          chk("addr_oob", int'(addr_oob), int'(e.oob));
        end
        wr_cnt++;
      end
      if (frame_done) begin
        chk("frame_writes", wr_cnt, NPIX);
        chk("busy_at_done", int'(busy), 0);
        // +1 counts the frame_start cycle itself as cycle 0.
        if (lat_chk) chk("frame_latency", cyc - start_cyc + 1, FRAME_CYC);
        wr_cnt = 0;
        done_seen = 1'b1;
      end
    end
  end

  task automatic issue(input bit md, input int c, input int s);
    @(negedge clk);
    frame_start = 1'b1; mode = md; cos_in = TW'(c); sin_in = TW'(s);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        exp_q.push_back(model(x, y, md, c, s));
    done_seen = 1'b0;
    @(posedge clk);
    #1 start_cyc = cyc;
    @(negedge clk);
    frame_start = 1'b0;
    chk("busy_rise", int'(busy), 1);
    // Scramble inputs: the frame must keep the values latched at start.
    mode = ~md; cos_in = TW'($urandom); sin_in = TW'($urandom);
  endtask

  // stall: 0 none, 1 five-cycle burst mid-row, 2 random.
  task automatic run_frame(input bit md, input int c, input int s, input int stall, input bit poke);
    lat_chk = (stall == 0);
    issue(md, c, s);
    for (int n = 0; n < 600 && !done_seen; n++) begin
      if (stall == 1)      addr_fifo_full = (n >= 12 && n < 17);
      else if (stall == 2) addr_fifo_full = ($urandom_range(0, 3) == 0);
      else                 addr_fifo_full = 1'b0;
      frame_start = (poke && n == 10);
      @(negedge clk);
    end
    addr_fifo_full = 1'b0;
    frame_start = 1'b0;
    chk("frame_timeout", int'(done_seen), 1);
    chk("queue_empty", exp_q.size(), 0);
    exp_q.delete();
  endtask

  function automatic int rnd_trig();
    return int'($urandom_range(0, 2 * ONE)) - ONE;
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_addr_x", int'(addr_x), 0);
    chk("rst_addr_y", int'(addr_y), 0);
    chk("rst_addr_oob", int'(addr_oob), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(1'b0, 0, 0, 0, 1'b0);        // identity
    run_frame(1'b1, -ONE, 0, 0, 1'b0);     // 180 degrees
    run_frame(1'b1, 0, ONE, 0, 1'b0);      // 90 degrees, mostly out of frame
    run_frame(1'b1, 0, -ONE, 0, 1'b1);     // 270 degrees, ignored restart
    run_frame(1'b0, 0, 0, 1, 1'b0);        // burst stall
    run_frame(1'b1, ONE, 0, 2, 1'b0);      // 0 degrees via rotate path
    for (int i = 0; i < 4; i++) run_frame(1'b1, rnd_trig(), rnd_trig(), 2, 1'b1);
    run_frame(1'b1, 11585, 11585, 0, 1'b0); // 45 degrees

    // Abort a frame with reset and confirm it stays idle afterwards.
    issue(1'b1, 0, ONE);
    repeat (12) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_wr_en", int'(wr_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_addr_x", int'(addr_x), 0);
    chk("abort_addr_y", int'(addr_y), 0);
    chk("abort_oob", int'(addr_oob), 0);
    exp_q.delete();
    wr_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("post_abort_wr_en", int'(wr_en), 0);
      chk("post_abort_busy", int'(busy), 0);
    end
    run_frame(1'b1, -ONE, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
